byte_group_arbiter_8to12: RTL and testbench

//  Shares one 8->12 packer between N_REQ byte-stream requesters with a round-robin policy.

---
 rtl/byte_group_arbiter_8to12.sv | 187 ++++++++++++++++++
 tb/tb_byte_group_arbiter_8to12.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_group_arbiter_8to12.sv
// byte_group_arbiter_8to12
// Round-robin arbiter that shares one 8->12 packer between N_REQ byte streams.
// A grant covers whole 3-byte groups, so one packed word never holds bytes from
// two sources and the packer phase stays aligned. A source that stalls mid-group
// for TIMEOUT cycles has its group completed with zero pad bytes.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin starting at rr_ptr
// XFER  | granted source streams bytes; release only on a group boundary
// PAD   | granted source timed out mid-group; emit 8'h00 until group complete
module byte_group_arbiter_8to12 #(
    parameter int N_REQ      = 2,
    parameter int MAX_GROUPS = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [8*N_REQ-1:0]       req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     pk_valid_o,
    output logic [7:0]               pk_data_o,
    output logic [$clog2(N_REQ)-1:0] pk_src_o,
    output logic                     pk_pad_o,
    output logic                     busy_o
);

    localparam int SW = $clog2(N_REQ);
    localparam int GW = $clog2(MAX_GROUPS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]   grant_q, grant_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [GW-1:0]   grp_cnt_q, grp_cnt_d;
    logic [TW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            pk_valid_q, pk_valid_d;
    logic [7:0]      pk_data_q, pk_data_d;
    logic [SW-1:0]   pk_src_q, pk_src_d;
    logic            pk_pad_q, pk_pad_d;

    logic            found;
    logic [SW-1:0]   pick;
    int              cand;
    logic            grant_valid;
    logic [7:0]      grant_byte;

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
        if (i == SW'(N_REQ - 1)) begin
            return '0;
        end
        return i + SW'(1);
    endfunction

    // Grant one-hot ready, derived only from registered state.
    always_comb begin
        req_ready_o = '0;
        if (state_q == XFER) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign pk_valid_o = pk_valid_q;
    assign pk_data_o  = pk_data_q;
    assign pk_src_o   = pk_src_q;
    assign pk_pad_o   = pk_pad_q;

    // Round-robin pick, next-state and registered packer-side outputs.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        byte_cnt_d  = byte_cnt_q;
        grp_cnt_d   = grp_cnt_q;
        stall_cnt_d = stall_cnt_q;
        pk_valid_d  = 1'b0;
        pk_data_d   = pk_data_q;
        pk_src_d    = pk_src_q;
        pk_pad_d    = pk_pad_q;
        found       = 1'b0;
        pick        = '0;
        cand        = 0;

        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = SW'(cand);
            end
        end

        grant_valid = req_valid_i[grant_q];
        grant_byte  = req_data_i[8*grant_q +: 8];

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d     = pick;
                    state_d     = XFER;
                    byte_cnt_d  = '0;
                    grp_cnt_d   = '0;
                    stall_cnt_d = '0;
                end
            end
            XFER: begin
                if (grant_valid) begin
                    pk_valid_d  = 1'b1;
                    pk_data_d   = grant_byte;
                    pk_src_d    = grant_q;
                    pk_pad_d    = 1'b0;
                    stall_cnt_d = '0;
                    if (byte_cnt_q == 2'd2) begin
                        byte_cnt_d = '0;
                        grp_cnt_d  = grp_cnt_q + GW'(1);
                        if (grp_cnt_q == GW'(MAX_GROUPS - 1)) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_idx(grant_q);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (byte_cnt_q == 2'd0) begin
                    // Source went quiet on a group boundary: give others a turn.
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(grant_q);
                end else begin
                    stall_cnt_d = stall_cnt_q + TW'(1);
                    if (stall_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                pk_valid_d = 1'b1;
                pk_data_d  = 8'h00;
                pk_src_d   = grant_q;
                pk_pad_d   = 1'b1;
                if (byte_cnt_q == 2'd2) begin
                    byte_cnt_d = '0;
                    state_d    = IDLE;
                    rr_ptr_d   = next_idx(grant_q);
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial group.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            byte_cnt_q  <= '0;
            grp_cnt_q   <= '0;
            stall_cnt_q <= '0;
            pk_valid_q  <= 1'b0;
            pk_data_q   <= 8'h00;
            pk_src_q    <= '0;
            pk_pad_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            byte_cnt_q  <= byte_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            pk_valid_q  <= pk_valid_d;
            pk_data_q   <= pk_data_d;
            pk_src_q    <= pk_src_d;
            pk_pad_q    <= pk_pad_d;
        end
    end

endmodule

// File: tb/tb_byte_group_arbiter_8to12.sv
// Bench for byte_group_arbiter_8to12: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_byte_group_arbiter_8to12;

    localparam int N    = 2;
    localparam int MAXG = 4;
    localparam int TO   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           pk_valid;
    logic [7:0]     pk_data;
    logic [0:0]     pk_src;
    logic           pk_pad;
    logic           busy;

    always #5 clk = ~clk;

    byte_group_arbiter_8to12 #(.N_REQ(N), .MAX_GROUPS(MAXG), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .pk_valid_o  (pk_valid),
        .pk_data_o   (pk_data),
        .pk_src_o    (pk_src),
        .pk_pad_o    (pk_pad),
        .busy_o      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Requester-side byte queues: a byte stays at the front until accepted.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [N-1:0] en = '0;

    // Observed packer stream.
    int log_d[$];
    int log_s[$];
    int log_p[$];
    int log_c[$];

    // Model: owner (-1 none), bytes into current group, groups done, stall run.
    int m_own = -1, m_pos = 0, m_groups = 0, m_stall = 0, m_rr = 0;
    bit m_padding = 0;
    bit m_pkv = 0, m_pkpad = 0;
    int m_pkd = 0, m_src = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic m_release();
        m_rr      = (m_own + 1) % N;
        m_own     = -1;
        m_padding = 0;
        m_pos     = 0;
    endtask

    task automatic model_step(input logic [N-1:0] v, input logic [8*N-1:0] d,
                              input bit r, output int acc);
        acc = -1;
        if (r) begin
            m_own = -1; m_pos = 0; m_groups = 0; m_stall = 0; m_rr = 0; m_padding = 0;
            m_pkv = 0; m_pkd = 0; m_src = 0; m_pkpad = 0;
            return;
        end
        m_pkv = 0;
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_own < 0 && v[(m_rr + k) % N]) m_own = (m_rr + k) % N;
            end
            if (m_own >= 0) begin
                m_pos = 0; m_groups = 0; m_stall = 0; m_padding = 0;
            end
        end else if (m_padding) begin
            m_pkv = 1; m_pkd = 0; m_src = m_own; m_pkpad = 1;
            m_pos++;
            if (m_pos == 3) m_release();
        end else if (v[m_own]) begin
            acc = m_own;
            m_pkv = 1; m_pkd = int'(d[8*m_own +: 8]); m_src = m_own; m_pkpad = 0;
            m_stall = 0;
            m_pos++;
            if (m_pos == 3) begin
                m_pos = 0;
                m_groups++;
                if (m_groups == MAXG) m_release();
            end
        end else if (m_pos == 0) begin
            m_release();
        end else begin
            m_stall++;
            if (m_stall == TO) m_padding = 1;
        end
    endtask

    task automatic tick(input bit r);
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        int             acc;
        int             exp_rdy;
        v[0] = en[0] && (q0.size() > 0);
        v[1] = en[1] && (q1.size() > 0);
        d[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
        d[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
        req_valid = v;
        req_data  = d;
        rst       = r;
        model_step(v, d, r, acc);
        @(posedge clk);
        #1;
        cyc++;
        if (acc == 0) void'(q0.pop_front());
        if (acc == 1) void'(q1.pop_front());
        exp_rdy = (m_own >= 0 && !m_padding) ? (1 << m_own) : 0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(m_own >= 0));
        chk("pk_valid", 32'(pk_valid), 32'(m_pkv));
        chk("pk_data", 32'(pk_data), 32'(m_pkd));
        chk("pk_src", 32'(pk_src), 32'(m_src));
        chk("pk_pad", 32'(pk_pad), 32'(m_pkpad));
        if (pk_valid === 1'b1) begin
            log_d.push_back(int'(pk_data));
            log_s.push_back(int'(pk_src));
            log_p.push_back(int'(pk_pad));
            log_c.push_back(cyc);
        end
    endtask

    task automatic wait_log(input int k);
        int b = 0;
        while (log_d.size() < k && b < 200) begin
            tick(0);
            b++;
        end
        chk("wait_log_bound", 32'(log_d.size() >= k), 32'd1);
    endtask

    task automatic start_test();
        en = '0;
        q0.delete();
        q1.delete();
        tick(1);
        log_d.delete(); log_s.delete(); log_p.delete(); log_c.delete();
    endtask

    function automatic int word0(input int b0, input int b1);
        return ((b0 << 4) | (b1 >> 4)) & 32'hfff;
    endfunction

    function automatic int word1(input int b1, input int b2);
        return (((b1 & 32'hf) << 8) | b2) & 32'hfff;
    endfunction

    int off[N];
    int errs;

    initial begin
        tick(1);
        tick(1);

        // T1: req0 alone, 0x11..0x16 back to back.
        start_test();
        for (int i = 0; i < 6; i++) q0.push_back(8'(8'h11 + i));
        en = 2'b01;
        wait_log(6);
        if (log_d.size() >= 6) begin
            chk("t1_span", 32'(log_c[5] - log_c[0]), 32'd5);
            chk("t1_b0", 32'(log_d[0]), 32'h11);
            chk("t1_b5", 32'(log_d[5]), 32'h16);
            chk("t1_w0", 32'(word0(log_d[0], log_d[1])), 32'h111);
            chk("t1_w1", 32'(word1(log_d[1], log_d[2])), 32'h213);
            chk("t1_w2", 32'(word0(log_d[3], log_d[4])), 32'h141);
            chk("t1_w3", 32'(word1(log_d[4], log_d[5])), 32'h516);
            chk("t1_src_pad", 32'(log_s[2] | log_p[2]), 32'd0);
        end
        repeat (4) tick(0);

        // T2: both always valid, 12-byte bursts alternate.
        start_test();
        for (int i = 0; i < 30; i++) begin
            q0.push_back(8'(8'h40 + i));
            q1.push_back(8'(8'h80 + i));
        end
        en = 2'b11;
        wait_log(26);
        if (log_d.size() >= 26) begin
            errs = 0;
            for (int k = 0; k < 24; k++) if (log_s[k] != ((k < 12) ? 0 : 1)) errs++;
            chk("t2_src_pattern", 32'(errs), 32'd0);
            chk("t2_idle_gap", 32'(log_c[12] - log_c[11]), 32'd2);
            chk("t2_burst_span", 32'(log_c[11] - log_c[0]), 32'd11);
            chk("t2_first_src1", 32'(log_d[12]), 32'h80);
            chk("t2_back_to_src0", 32'(log_s[24]), 32'd0);
        end

        // T3: three-cycle stall after byte 1 is not padded.
        start_test();
        q0.push_back(8'h31); q0.push_back(8'h32); q0.push_back(8'h33);
        en = 2'b01;
        wait_log(1);
        en = 2'b00;
        repeat (3) tick(0);
        en = 2'b01;
        wait_log(3);
        if (log_d.size() >= 3) begin
            chk("t3_gap", 32'(log_c[1] - log_c[0]), 32'd4);
            chk("t3_b1", 32'(log_d[1]), 32'h32);
            chk("t3_no_pad", 32'(log_p[1] | log_p[2]), 32'd0);
            chk("t3_b2_next", 32'(log_c[2] - log_c[1]), 32'd1);
        end
        repeat (4) tick(0);

        // T4: 0xAB then silence -> two pads after 8 stall cycles, then req1.
        start_test();
        q0.push_back(8'hAB);
        en = 2'b01;
        wait_log(1);
        repeat (5) tick(0);
        q1.push_back(8'hC1); q1.push_back(8'hC2); q1.push_back(8'hC3);
        en = 2'b11;
        wait_log(4);
        if (log_d.size() >= 4) begin
            chk("t4_pad_delay", 32'(log_c[1] - log_c[0]), 32'd9);
            chk("t4_pad_flags", 32'(log_p[1] + log_p[2]), 32'd2);
            chk("t4_pad_src", 32'(log_s[2]), 32'd0);
            chk("t4_w0", 32'(word0(log_d[0], log_d[1])), 32'hAB0);
            chk("t4_w1", 32'(word1(log_d[1], log_d[2])), 32'h000);
            chk("t4_next_src", 32'(log_s[3]), 32'd1);
            chk("t4_next_byte", 32'(log_d[3]), 32'hC1);
        end
        repeat (6) tick(0);

        // T5: req0 drops valid on a boundary after one group.
        start_test();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'(8'h51 + i));
            q1.push_back(8'(8'h61 + i));
        end
        en = 2'b11;
        wait_log(4);
        if (log_d.size() >= 4) begin
            chk("t5_src_before", 32'(log_s[2]), 32'd0);
            chk("t5_src_after", 32'(log_s[3]), 32'd1);
            chk("t5_gap", 32'(log_c[3] - log_c[2]), 32'd3);
            chk("t5_byte", 32'(log_d[3]), 32'h61);
        end
        repeat (6) tick(0);

        // T6: reset after byte 2 of a group.
        start_test();
        for (int i = 0; i < 6; i++) q0.push_back(8'(8'h71 + i));
        en = 2'b01;
        wait_log(2);
        tick(1);
        chk("t6_rst_outs", 32'({req_ready, pk_valid, pk_data, pk_src, pk_pad, busy}), 32'd0);
        log_d.delete(); log_s.delete(); log_p.delete(); log_c.delete();
        wait_log(3);
        if (log_d.size() >= 3) begin
            chk("t6_fresh_byte", 32'(log_d[0]), 32'h73);
            chk("t6_fresh_span", 32'(log_c[2] - log_c[0]), 32'd2);
        end
        repeat (20) tick(0);

        // Randomized traffic with short and long stalls and occasional reset.
        start_test();
        off[0] = 0;
        off[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            while (q0.size() < 3) q0.push_back(8'($urandom_range(0, 255)));
            while (q1.size() < 3) q1.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < N; i++) begin
                if (off[i] > 0) begin
                    en[i] = 1'b0;
                    off[i]--;
                end else begin
                    en[i] = 1'b1;
                    if ($urandom_range(0, 7) == 0) off[i] = $urandom_range(1, 3);
                    else if ($urandom_range(0, 39) == 0) off[i] = $urandom_range(9, 14);
                end
            end
            tick($urandom_range(0, 599) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
